// File: rtl/mig_pkg.sv
// rtl/mig_pkg.sv - shared types and sizes for the MIG evaluator
package mig_pkg;
  localparam int N_IN    = 7;
  localparam int N_NODES = 16;
  localparam int IDX_W   = $clog2(1 + N_IN + N_NODES);
  localparam int ADDR_W  = $clog2(N_NODES);
  localparam int LEN_W   = $clog2(N_NODES + 1);
  localparam int SPACE_W = 1 << IDX_W;

  typedef struct packed {
    logic             inv;
    logic [IDX_W-1:0] idx;
  } mig_opnd_t;

  typedef struct packed {
    mig_opnd_t a;
    mig_opnd_t b;
    mig_opnd_t c;
  } mig_node_t;

  localparam int NODE_W = $bits(mig_node_t);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} mig_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/mig_opnd_mux.sv
// rtl/mig_opnd_mux.sv - selects one operand bit from {0, x, node results}, optionally inverted
module mig_opnd_mux
  import mig_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  input  logic               inv,
  input  logic [N_IN-1:0]    x,
  input  logic [N_NODES-1:0] nodes,
  output logic               y
);
  logic [SPACE_W-1:0] space;

  // Unused upper indices stay zero so out-of-range operands read 0.
  always_comb begin
    space = '0;
    space[N_IN+N_NODES:0] = {nodes, x, 1'b0};
    y = space[idx] ^ inv;
  end
endmodule

// File: rtl/mig_eval_engine.sv
// rtl/mig_eval_engine.sv - programmable majority-inverter-graph evaluator, one node per clock
module mig_eval_engine
  import mig_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [NODE_W-1:0] cfg_data,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_len_we,
  input  logic [IDX_W-1:0]  cfg_osel,
  input  logic              cfg_oinv,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_y
);
  mig_state_t          state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [N_IN-1:0]     x_q, x_d;
  logic [N_NODES-1:0]  node_q, node_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [IDX_W-1:0]    osel_q, osel_d;
  logic                oinv_q, oinv_d;
  mig_node_t           prog_q [N_NODES];
  mig_node_t           prog_d [N_NODES];

  mig_node_t cur;
  logic      op_a, op_b, op_c, sel_y;
  logic      accept, cfg_ok;

  assign cur    = prog_q[k_q];
  assign accept = in_valid & in_ready_q;
  // Config may only land while idle and not racing a vector accept.
  assign cfg_ok = (state_q == IDLE) & ~accept;

  mig_opnd_mux u_mux_a (.idx(cur.a.idx), .inv(cur.a.inv), .x(x_q), .nodes(node_q), .y(op_a));
  mig_opnd_mux u_mux_b (.idx(cur.b.idx), .inv(cur.b.inv), .x(x_q), .nodes(node_q), .y(op_b));
  mig_opnd_mux u_mux_c (.idx(cur.c.idx), .inv(cur.c.inv), .x(x_q), .nodes(node_q), .y(op_c));
  mig_opnd_mux u_mux_o (.idx(osel_q),    .inv(oinv_q),    .x(x_q), .nodes(node_q), .y(sel_y));

  assign cfg_err   = (cfg_we | cfg_len_we) & ~cfg_ok & ~rst;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_y     = out_valid_q & sel_y;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    node_d  = node_q;
    k_d     = k_q;
    len_d   = len_q;
    osel_d  = osel_q;
    oinv_d  = oinv_q;
    prog_d  = prog_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          x_d     = in_x;
          node_d  = '0;
          k_d     = '0;
          state_d = (len_q == '0) ? DONE : EVAL;
        end
      end
      EVAL: begin
        node_d[k_q] = maj3(op_a, op_b, op_c);
        if (LEN_W'(k_q) == len_q - LEN_W'(1)) begin
          state_d = DONE;
        end else begin
          k_d = k_q + ADDR_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cfg_ok && cfg_we) begin
      prog_d[cfg_addr] = mig_node_t'(cfg_data);
    end
    if (cfg_ok && cfg_len_we) begin
      len_d  = (cfg_len > LEN_W'(N_NODES)) ? LEN_W'(N_NODES) : cfg_len;
      osel_d = cfg_osel;
      oinv_d = cfg_oinv;
    end

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      node_q      <= '0;
      k_q         <= '0;
      len_q       <= '0;
      osel_q      <= '0;
      oinv_q      <= 1'b0;
      for (int i = 0; i < N_NODES; i++) begin
        prog_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      node_q      <= node_d;
      k_q         <= k_d;
      len_q       <= len_d;
      osel_q      <= osel_d;
      oinv_q      <= oinv_d;
      prog_q      <= prog_d;
    end
  end
endmodule

// File: tb/tb_mig_eval_engine.sv
// tb/tb_mig_eval_engine.sv - self-checking bench for mig_eval_engine
module tb_mig_eval_engine;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [17:0] cfg_data;
  logic [4:0]  cfg_len;
  logic        cfg_len_we;
  logic [4:0]  cfg_osel;
  logic        cfg_oinv;
  logic        cfg_err;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_x;
  logic        out_valid;
  logic        out_ready;
  logic        out_y;

  int checks = 0;
  int failures = 0;

  logic [17:0] mprog [16];
  int          mlen;
  logic [4:0]  mosel;
  logic        moinv;

  localparam logic [17:0] NODE_X012   = {1'b0, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3};
  localparam logic [17:0] NODE_CHAIN1 = {1'b0, 5'd4, 1'b0, 5'd8, 1'b1, 5'd5};

  mig_eval_engine dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_len(cfg_len), .cfg_len_we(cfg_len_we), .cfg_osel(cfg_osel), .cfg_oinv(cfg_oinv),
    .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
  );

  always #5 clk = ~clk;

  function automatic logic opval(input logic [4:0] idx, input logic [6:0] x, input logic [15:0] nodes);
    int i;
    i = int'(idx);
    if (i == 0) return 1'b0;
    if (i <= 7) return x[i-1];
    if (i <= 23) return nodes[i-8];
    return 1'b0;
  endfunction

  function automatic logic model_eval(input logic [6:0] x);
    logic [15:0] nodes;
    logic [17:0] n;
    int          a, b, c;
    nodes = '0;
    for (int k = 0; k < mlen; k++) begin
      n = mprog[k];
      a = int'(opval(n[16:12], x, nodes) ^ n[17]);
      b = int'(opval(n[10:6], x, nodes) ^ n[11]);
      c = int'(opval(n[4:0], x, nodes) ^ n[5]);
      nodes[k] = (a + b + c >= 2);
    end
    return opval(mosel, x, nodes) ^ moinv;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mprog[i] = '0;
    mlen = 0;
    mosel = '0;
    moinv = 1'b0;
  endtask

  task automatic cfg(input logic we, input int addr, input logic [17:0] data,
                     input logic lwe, input logic [4:0] len, input logic [4:0] osel, input logic oinv);
    cfg_we = we; cfg_addr = 4'(addr); cfg_data = data;
    cfg_len_we = lwe; cfg_len = len; cfg_osel = osel; cfg_oinv = oinv;
    #1;
    checks++;
    if (cfg_err !== 1'b0) $display("FAIL cfg_idle_err got=%b want=0", cfg_err);
    if (cfg_err !== 1'b0) failures++;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_len_we = 1'b0;
    if (we) mprog[addr] = data;
    if (lwe) begin
      mlen = (int'(len) > 16) ? 16 : int'(len);
      mosel = osel;
      moinv = oinv;
    end
  endtask

  task automatic run_vector(input logic [6:0] x, output logic y_obs);
    logic exp;
    int   cnt, lat;
    exp = model_eval(x);
    in_x = x; in_valid = 1'b1; cnt = 0;
    while (in_ready !== 1'b1 && cnt < 20) begin @(posedge clk); #1; cnt++; end
    checks++;
    if (in_ready !== 1'b1) begin $display("FAIL in_ready_timeout got=%b want=1", in_ready); failures++; end
    @(posedge clk); #1;
    in_valid = 1'b0; in_x = 7'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != mlen + 1) begin $display("FAIL latency x=%b got=%0d want=%0d", x, lat, mlen + 1); failures++; end
    checks++;
    if (out_y !== exp) begin $display("FAIL out_y x=%b got=%b want=%b", x, out_y, exp); failures++; end
    y_obs = out_y;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL return_idle got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
      failures++;
    end
  endtask

  task automatic wait_out_valid();
    int cnt;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 40) begin @(posedge clk); #1; cnt++; end
    checks++;
    if (out_valid !== 1'b1) begin $display("FAIL out_valid_timeout got=%b want=1", out_valid); failures++; end
  endtask

  task automatic test_reset();
    logic y;
    rst = 1'b1; cfg_we = 1'b1; cfg_len_we = 1'b1; cfg_addr = '0; cfg_data = NODE_X012;
    cfg_len = 5'd1; cfg_osel = 5'd8; cfg_oinv = 1'b1;
    in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_y !== 1'b0 || cfg_err !== 1'b0) begin
      $display("FAIL reset_outputs got ready=%b valid=%b y=%b err=%b want 0 0 0 0",
               in_ready, out_valid, out_y, cfg_err);
      failures++;
    end
    cfg_we = 1'b0; cfg_len_we = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin $display("FAIL reset_ready got=%b want=1", in_ready); failures++; end
    model_reset();
    run_vector(7'h7f, y);
    checks++;
    if (y !== 1'b0) begin $display("FAIL reset_empty_prog got=%b want=0", y); failures++; end
  endtask

  task automatic test_single_node();
    logic y;
    cfg(1'b1, 0, NODE_X012, 1'b1, 5'd1, 5'd8, 1'b0);
    run_vector(7'b0000011, y);
    checks++;
    if (y !== 1'b1) begin $display("FAIL single_x03 got=%b want=1", y); failures++; end
    run_vector(7'b0000100, y);
    checks++;
    if (y !== 1'b0) begin $display("FAIL single_x04 got=%b want=0", y); failures++; end
  endtask

  task automatic test_chain();
    logic y;
    cfg(1'b1, 0, NODE_X012, 1'b0, 5'd0, 5'd0, 1'b0);
    cfg(1'b1, 1, NODE_CHAIN1, 1'b1, 5'd2, 5'd9, 1'b0);
    for (int x = 0; x < 128; x++) run_vector(7'(x), y);
  endtask

  task automatic test_len0();
    logic y;
    cfg(1'b0, 0, '0, 1'b1, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_vector(7'($urandom), y);
      checks++;
      if (y !== 1'b1) begin $display("FAIL len0_const got=%b want=1", y); failures++; end
    end
  endtask

  task automatic test_random_programs();
    logic y;
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < 15; k++) cfg(1'b1, k, 18'($urandom), 1'b0, 5'd0, 5'd0, 1'b0);
      // last node and length written together in one cycle
      cfg(1'b1, 15, 18'($urandom), 1'b1, 5'($urandom_range(0, 31)), 5'($urandom), 1'($urandom));
      for (int v = 0; v < 8; v++) run_vector(7'($urandom), y);
    end
  endtask

  task automatic test_stall();
    logic exp;
    cfg(1'b1, 0, NODE_X012, 1'b1, 5'd1, 5'd8, 1'b0);
    exp = model_eval(7'b0000011);
    in_x = 7'b0000011; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_x = '0;
    wait_out_valid();
    cfg_len_we = 1'b1; cfg_len = 5'd0;
    #1;
    checks++;
    if (cfg_err !== 1'b1) begin $display("FAIL done_cfg_err got=%b want=1", cfg_err); failures++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_y !== exp || in_ready !== 1'b0) begin
        $display("FAIL stall_hold cyc=%0d got valid=%b y=%b ready=%b want 1 %b 0",
                 i, out_valid, out_y, in_ready, exp);
        failures++;
      end
      @(posedge clk); #1;
      cfg_len_we = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_y !== 1'b0) begin
      $display("FAIL stall_release got ready=%b valid=%b y=%b want 1 0 0", in_ready, out_valid, out_y);
      failures++;
    end
  endtask

  task automatic test_cfg_busy();
    logic       exp, y;
    logic [6:0] x;
    cfg(1'b1, 0, NODE_X012, 1'b0, 5'd0, 5'd0, 1'b0);
    cfg(1'b1, 1, NODE_CHAIN1, 1'b1, 5'd2, 5'd9, 1'b0);
    for (int t = 0; t < 4; t++) begin
      x = 7'($urandom);
      exp = model_eval(x);
      in_x = x; in_valid = 1'b1;
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = '0;
      #1;
      checks++;
      if (cfg_err !== 1'b1) begin $display("FAIL accept_cycle_cfg_err got=%b want=1", cfg_err); failures++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      cfg_data = 18'h3ffff; cfg_len_we = 1'b1; cfg_len = 5'd0; cfg_osel = 5'd0; cfg_oinv = 1'b1;
      #1;
      checks++;
      if (cfg_err !== 1'b1) begin $display("FAIL eval_cfg_err got=%b want=1", cfg_err); failures++; end
      @(posedge clk); #1;
      cfg_we = 1'b0; cfg_len_we = 1'b0;
      #1;
      checks++;
      if (cfg_err !== 1'b0) begin $display("FAIL cfg_err_pulse got=%b want=0", cfg_err); failures++; end
      wait_out_valid();
      checks++;
      if (out_y !== exp) begin $display("FAIL busy_result x=%b got=%b want=%b", x, out_y, exp); failures++; end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    run_vector(7'($urandom), y);
  endtask

  task automatic test_reset_mid_eval();
    logic y;
    cfg(1'b1, 0, NODE_X012, 1'b1, 5'd1, 5'd8, 1'b0);
    in_x = 7'b0000011; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_y !== 1'b0) begin
      $display("FAIL mid_reset got valid=%b ready=%b y=%b want 0 0 0", out_valid, in_ready, out_y);
      failures++;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL post_reset got ready=%b valid=%b want 1 0", in_ready, out_valid);
      failures++;
    end
    model_reset();
    cfg(1'b0, 0, '0, 1'b1, 5'd1, 5'd8, 1'b0);
    run_vector(7'b0000111, y);
    checks++;
    if (y !== 1'b0) begin $display("FAIL program_erased got=%b want=0", y); failures++; end
  endtask

  initial begin
    test_reset();
    test_single_node();
    test_chain();
    test_len0();
    test_random_programs();
    test_stall();
    test_cfg_busy();
    test_reset_mid_eval();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
